// File: rtl/axi_remap_bridge.sv
// axi_remap_bridge
// Single-outstanding AXI write-channel bridge that remaps the write address
// through a small table of base/mask/offset windows. Addresses that match no
// enabled window are absorbed locally: the data beats are drained and a
// DECERR response is returned without touching the downstream port.

module axi_remap_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int ID_W    = 4,
    parameter int NUM_WIN = 4,
    localparam int CW     = $clog2(NUM_WIN) + 2
) (
    input  logic                clock,
    input  logic                reset,

    // upstream write address
    input  logic                io_in_awvalid,
    output logic                io_in_awready,
    input  logic [ADDR_W-1:0]   io_in_awaddr,
    input  logic [ID_W-1:0]     io_in_awid,
    input  logic [7:0]          io_in_awlen,
    input  logic [2:0]          io_in_awsize,
    input  logic [1:0]          io_in_awburst,

    // upstream write data
    input  logic                io_in_wvalid,
    output logic                io_in_wready,
    input  logic [DATA_W-1:0]   io_in_wdata,
    input  logic [DATA_W/8-1:0] io_in_wstrb,
    input  logic                io_in_wlast,

    // upstream write response
    output logic                io_in_bvalid,
    input  logic                io_in_bready,
    output logic [1:0]          io_in_bresp,
    output logic [ID_W-1:0]     io_in_bid,

    // downstream write address
    output logic                io_out_awvalid,
    input  logic                io_out_awready,
    output logic [ADDR_W-1:0]   io_out_awaddr,
    output logic [ID_W-1:0]     io_out_awid,
    output logic [7:0]          io_out_awlen,
    output logic [2:0]          io_out_awsize,
    output logic [1:0]          io_out_awburst,

    // downstream write data
    output logic                io_out_wvalid,
    input  logic                io_out_wready,
    output logic [DATA_W-1:0]   io_out_wdata,
    output logic [DATA_W/8-1:0] io_out_wstrb,
    output logic                io_out_wlast,

    // downstream write response
    input  logic                io_out_bvalid,
    output logic                io_out_bready,
    input  logic [1:0]          io_out_bresp,
    input  logic [ID_W-1:0]     io_out_bid,

    // window configuration
    input  logic                cfg_wen,
    input  logic [CW-1:0]       cfg_addr,
    input  logic [ADDR_W-1:0]   cfg_wdata,

    output logic [15:0]         err_count
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        RESP,
        ERR_DATA,
        ERR_RESP
    } state_t;

    // Saturating increment for the DECERR counter.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Window table
    logic [ADDR_W-1:0] win_base [NUM_WIN];
    logic [ADDR_W-1:0] win_mask [NUM_WIN];
    logic [ADDR_W-1:0] win_off  [NUM_WIN];
    logic              win_en   [NUM_WIN];

    // Lookup result for the address currently presented upstream
    logic              hit;
    logic [ADDR_W-1:0] xlat_addr;

    // Burst context captured at AW acceptance
    state_t            state_q;
    logic              awready_q;
    logic              out_awvalid_q;
    logic [ADDR_W-1:0] cap_addr;
    logic [ID_W-1:0]   cap_id;
    logic [7:0]        cap_len;
    logic [2:0]        cap_size;
    logic [1:0]        cap_burst;
    logic [15:0]       err_cnt_q;

    // The downstream B id is not forwarded; the captured id is returned instead.
    logic unused_out_bid;
    assign unused_out_bid = ^io_out_bid;

    // Register writes: word k of window i sits at 4*i + k.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_WIN; i++) begin
                win_base[i] <= '0;
                win_mask[i] <= '0;
                win_off[i]  <= '0;
                win_en[i]   <= 1'b0;
            end
        end else if (cfg_wen) begin
            for (int i = 0; i < NUM_WIN; i++) begin
                if (int'(cfg_addr >> 2) == i) begin
                    unique case (cfg_addr[1:0])
                        2'd0: win_base[i] <= cfg_wdata;
                        2'd1: win_mask[i] <= cfg_wdata;
                        2'd2: win_off[i]  <= cfg_wdata;
                        default: win_en[i] <= cfg_wdata[0];
                    endcase
                end
            end
        end
    end

    // Window match; scanning from the top down lets the lowest hit index win.
    always_comb begin
        hit       = 1'b0;
        xlat_addr = io_in_awaddr;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if (win_en[i] && ((io_in_awaddr & win_mask[i]) == (win_base[i] & win_mask[i]))) begin
                hit       = 1'b1;
                xlat_addr = io_in_awaddr + win_off[i];
            end
        end
    end

    // Burst sequencing, context capture and DECERR counting.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            awready_q     <= 1'b1;
            out_awvalid_q <= 1'b0;
            cap_addr      <= '0;
            cap_id        <= '0;
            cap_len       <= '0;
            cap_size      <= '0;
            cap_burst     <= '0;
            err_cnt_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (io_in_awvalid) begin
                        cap_addr  <= xlat_addr;
                        cap_id    <= io_in_awid;
                        cap_len   <= io_in_awlen;
                        cap_size  <= io_in_awsize;
                        cap_burst <= io_in_awburst;
                        awready_q <= 1'b0;
                        if (hit) begin
                            out_awvalid_q <= 1'b1;
                            state_q       <= ADDR;
                        end else begin
                            state_q       <= ERR_DATA;
                        end
                    end
                end
                ADDR: begin
                    if (io_out_awready) begin
                        out_awvalid_q <= 1'b0;
                        state_q       <= DATA;
                    end
                end
                DATA: begin
                    if (io_in_wvalid && io_out_wready && io_in_wlast) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (io_out_bvalid && io_in_bready) begin
                        awready_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                ERR_DATA: begin
                    if (io_in_wvalid && io_in_wlast) begin
                        state_q <= ERR_RESP;
                    end
                end
                ERR_RESP: begin
                    if (io_in_bready) begin
                        err_cnt_q <= sat_inc(err_cnt_q);
                        awready_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // W and B pass straight through while a mapped burst owns them; the error
    // path answers locally and keeps every downstream handshake quiet.
    always_comb begin
        io_in_wready  = 1'b0;
        io_out_wvalid = 1'b0;
        io_in_bvalid  = 1'b0;
        io_in_bresp   = 2'b00;
        io_out_bready = 1'b0;
        unique case (state_q)
            DATA: begin
                io_out_wvalid = io_in_wvalid;
                io_in_wready  = io_out_wready;
            end
            ERR_DATA: begin
                io_in_wready = 1'b1;
            end
            RESP: begin
                io_in_bvalid  = io_out_bvalid;
                io_in_bresp   = io_out_bresp;
                io_out_bready = io_in_bready;
            end
            ERR_RESP: begin
                io_in_bvalid = 1'b1;
                io_in_bresp  = 2'b11;
            end
            default: ;
        endcase
    end

    assign io_in_awready  = awready_q;
    assign io_in_bid      = cap_id;

    assign io_out_awvalid = out_awvalid_q;
    assign io_out_awaddr  = cap_addr;
    assign io_out_awid    = cap_id;
    assign io_out_awlen   = cap_len;
    assign io_out_awsize  = cap_size;
    assign io_out_awburst = cap_burst;

    assign io_out_wdata   = io_in_wdata;
    assign io_out_wstrb   = io_in_wstrb;
    assign io_out_wlast   = io_in_wlast;

    assign err_count      = err_cnt_q;

endmodule

// File: tb/tb_axi_remap_bridge.sv
// Bench for axi_remap_bridge: directed scenarios followed by randomized
// bursts, all checked against a table-lookup reference model of the windows.

module tb_axi_remap_bridge;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 64;
    localparam int ID_W    = 4;
    localparam int NUM_WIN = 4;
    localparam int CW      = 4;

    logic clock, reset;
    logic io_in_awvalid, io_in_awready;
    logic [ADDR_W-1:0] io_in_awaddr;
    logic [ID_W-1:0] io_in_awid;
    logic [7:0] io_in_awlen;
    logic [2:0] io_in_awsize;
    logic [1:0] io_in_awburst;
    logic io_in_wvalid, io_in_wready;
    logic [DATA_W-1:0] io_in_wdata;
    logic [DATA_W/8-1:0] io_in_wstrb;
    logic io_in_wlast;
    logic io_in_bvalid, io_in_bready;
    logic [1:0] io_in_bresp;
    logic [ID_W-1:0] io_in_bid;
    logic io_out_awvalid, io_out_awready;
    logic [ADDR_W-1:0] io_out_awaddr;
    logic [ID_W-1:0] io_out_awid;
    logic [7:0] io_out_awlen;
    logic [2:0] io_out_awsize;
    logic [1:0] io_out_awburst;
    logic io_out_wvalid, io_out_wready;
    logic [DATA_W-1:0] io_out_wdata;
    logic [DATA_W/8-1:0] io_out_wstrb;
    logic io_out_wlast;
    logic io_out_bvalid, io_out_bready;
    logic [1:0] io_out_bresp;
    logic [ID_W-1:0] io_out_bid;
    logic cfg_wen;
    logic [CW-1:0] cfg_addr;
    logic [ADDR_W-1:0] cfg_wdata;
    logic [15:0] err_count;

    axi_remap_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .NUM_WIN(NUM_WIN)) dut (
        .clock(clock), .reset(reset),
        .io_in_awvalid(io_in_awvalid), .io_in_awready(io_in_awready), .io_in_awaddr(io_in_awaddr),
        .io_in_awid(io_in_awid), .io_in_awlen(io_in_awlen), .io_in_awsize(io_in_awsize),
        .io_in_awburst(io_in_awburst),
        .io_in_wvalid(io_in_wvalid), .io_in_wready(io_in_wready), .io_in_wdata(io_in_wdata),
        .io_in_wstrb(io_in_wstrb), .io_in_wlast(io_in_wlast),
        .io_in_bvalid(io_in_bvalid), .io_in_bready(io_in_bready), .io_in_bresp(io_in_bresp),
        .io_in_bid(io_in_bid),
        .io_out_awvalid(io_out_awvalid), .io_out_awready(io_out_awready), .io_out_awaddr(io_out_awaddr),
        .io_out_awid(io_out_awid), .io_out_awlen(io_out_awlen), .io_out_awsize(io_out_awsize),
        .io_out_awburst(io_out_awburst),
        .io_out_wvalid(io_out_wvalid), .io_out_wready(io_out_wready), .io_out_wdata(io_out_wdata),
        .io_out_wstrb(io_out_wstrb), .io_out_wlast(io_out_wlast),
        .io_out_bvalid(io_out_bvalid), .io_out_bready(io_out_bready), .io_out_bresp(io_out_bresp),
        .io_out_bid(io_out_bid),
        .cfg_wen(cfg_wen), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .err_count(err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    bit err_mode = 1'b0;

    // Reference model: window table and expected DECERR count.
    logic [31:0] m_base [NUM_WIN];
    logic [31:0] m_mask [NUM_WIN];
    logic [31:0] m_off  [NUM_WIN];
    bit          m_en   [NUM_WIN];
    int          m_err;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < NUM_WIN; i++) begin
            m_base[i] = '0; m_mask[i] = '0; m_off[i] = '0; m_en[i] = 1'b0;
        end
        m_err = 0;
    endfunction

    // First enabled window whose masked bits agree with the address decides.
    function automatic bit model_map(input logic [31:0] a, output logic [31:0] t);
        for (int i = 0; i < NUM_WIN; i++) begin
            if (m_en[i] && (((a ^ m_base[i]) & m_mask[i]) == 32'h0)) begin
                t = a + m_off[i];
                return 1'b1;
            end
        end
        t = a;
        return 1'b0;
    endfunction

    // While a miss is being absorbed nothing may move downstream.
    always @(negedge clock) begin
        if (err_mode)
            check_eq("no_downstream_in_err", {io_out_awvalid, io_out_wvalid, io_out_bready}, 64'h0);
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic cfg_write(input int w, input int k, input logic [31:0] d);
        cfg_wen = 1'b1; cfg_addr = CW'(w * 4 + k); cfg_wdata = d;
        @(posedge clock); #1;
        cfg_wen = 1'b0;
        case (k)
            0: m_base[w] = d;
            1: m_mask[w] = d;
            2: m_off[w]  = d;
            default: m_en[w] = d[0];
        endcase
    endtask

    task automatic set_window(input int w, input logic [31:0] b, input logic [31:0] m,
                              input logic [31:0] o, input bit en);
        cfg_write(w, 0, b);
        cfg_write(w, 1, m);
        cfg_write(w, 2, o);
        cfg_write(w, 3, {31'h0, en});
    endtask

    task automatic send_aw(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
        io_in_awvalid = 1'b1; io_in_awaddr = a; io_in_awid = id; io_in_awlen = len;
        io_in_awsize = 3'd3; io_in_awburst = 2'd1;
        @(negedge clock);
        check_eq("in_awready_idle", io_in_awready, 1);
        @(posedge clock); #1;
        io_in_awvalid = 1'b0; io_in_awaddr = $urandom; io_in_awid = 4'($urandom);
        io_in_awlen = 8'($urandom);
    endtask

    task automatic accept_out_aw(input logic [31:0] exp_a, input logic [3:0] id, input logic [7:0] len,
                                 input int delay, output logic [31:0] got);
        io_in_wvalid = 1'b1; io_in_wlast = 1'b1; io_out_wready = 1'b1;
        @(negedge clock);
        check_eq("out_awvalid_latency", io_out_awvalid, 1);
        check_eq("out_awaddr", io_out_awaddr, exp_a);
        check_eq("out_awid", io_out_awid, id);
        check_eq("out_awlen", io_out_awlen, len);
        check_eq("w_blocked_in_addr", {io_in_wready, io_out_wvalid, io_in_awready}, 64'h0);
        got = io_out_awaddr;
        io_in_wvalid = 1'b0; io_in_wlast = 1'b0; io_out_wready = 1'b0;
        repeat (delay) begin
            @(posedge clock); #1;
            @(negedge clock);
            check_eq("out_aw_hold", {io_out_awvalid, io_out_awaddr}, {1'b1, exp_a});
        end
        io_out_awready = 1'b1;
        @(posedge clock); #1;
        io_out_awready = 1'b0;
    endtask

    task automatic w_beat(input bit hit, input bit last, input int delay);
        logic [63:0] d;
        logic [7:0]  s;
        d = {$urandom, $urandom}; s = 8'($urandom);
        io_in_wvalid = 1'b1; io_in_wdata = d; io_in_wstrb = s; io_in_wlast = last;
        io_out_wready = 1'b0;
        if (hit) begin
            repeat (delay) begin
                @(negedge clock);
                check_eq("w_stall", {io_out_wvalid, io_in_wready}, 64'h2);
                check_eq("w_data_stall", io_out_wdata, d);
                @(posedge clock); #1;
            end
            io_out_wready = 1'b1;
            @(negedge clock);
            check_eq("w_pass_ctl", {io_out_wvalid, io_in_wready, io_out_wlast}, {61'h0, 2'b11, last});
            check_eq("w_pass_data", io_out_wdata, d);
            check_eq("w_pass_strb", io_out_wstrb, s);
        end else begin
            @(negedge clock);
            check_eq("w_drain", {io_out_wvalid, io_in_wready}, 64'h1);
        end
        @(posedge clock); #1;
        io_in_wvalid = 1'b0; io_in_wlast = 1'b0; io_out_wready = 1'b0;
    endtask

    task automatic b_phase(input bit hit, input logic [3:0] id, input int delay);
        logic [1:0] r;
        r = 2'($urandom);
        io_in_bready = 1'b0;
        if (hit) begin
            io_out_bvalid = 1'b1; io_out_bresp = r; io_out_bid = 4'($urandom);
        end
        for (int i = 0; i <= delay; i++) begin
            if (i == delay) io_in_bready = 1'b1;
            @(negedge clock);
            check_eq("in_bvalid", io_in_bvalid, 1);
            check_eq("in_bresp", io_in_bresp, hit ? r : 2'b11);
            check_eq("in_bid", io_in_bid, id);
            if (hit) check_eq("out_bready", io_out_bready, io_in_bready);
            if (i < delay) begin
                @(posedge clock); #1;
            end
        end
        @(posedge clock); #1;
        io_in_bready = 1'b0; io_out_bvalid = 1'b0;
        if (!hit) begin
            err_mode = 1'b0;
            if (m_err < 65535) m_err++;
        end
        @(negedge clock);
        check_eq("err_count", err_count, m_err);
        check_eq("back_to_idle", {io_in_awready, io_in_bvalid}, 64'h2);
        @(posedge clock); #1;
    endtask

    task automatic do_burst(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                            input bit do_cfg, input int cw, input int ck, input logic [31:0] cd,
                            output logic [31:0] got);
        bit hit;
        logic [31:0] exp_a;
        hit = model_map(a, exp_a);
        got = '0;
        send_aw(a, id, len);
        if (hit) accept_out_aw(exp_a, id, len, $urandom_range(0, 2), got);
        else err_mode = 1'b1;
        if (do_cfg) cfg_write(cw, ck, cd);
        for (int b = 0; b <= int'(len); b++) w_beat(hit, b == int'(len), $urandom_range(0, 2));
        b_phase(hit, id, $urandom_range(0, 2));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] a, mk;
        int w;
        reset = 1'b1; cfg_wen = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        io_in_awvalid = 0; io_in_awaddr = 0; io_in_awid = 0; io_in_awlen = 0;
        io_in_awsize = 0; io_in_awburst = 0;
        io_in_wvalid = 0; io_in_wdata = 0; io_in_wstrb = 0; io_in_wlast = 0; io_in_bready = 0;
        io_out_awready = 0; io_out_wready = 0; io_out_bvalid = 0; io_out_bresp = 0; io_out_bid = 0;
        model_clear();
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_eq("rst_awready", io_in_awready, 1);
        check_eq("rst_valids", {io_out_awvalid, io_out_wvalid, io_in_bvalid, io_in_wready}, 64'h0);
        check_eq("rst_err_count", err_count, 0);
        @(posedge clock); #1;

        // Basic remap
        set_window(0, 32'h8000_0000, 32'hFFF0_0000, 32'h0010_0000, 1'b1);
        do_burst(32'h8000_1000, 4'd5, 8'd3, 0, 0, 0, 0, got);
        check_eq("basic_remap", got, 32'h8010_1000);

        // Miss -> DECERR
        do_burst(32'h1000_0000, 4'd2, 8'd1, 0, 0, 0, 0, got);

        // Two hits: lowest index wins
        set_window(0, 32'h4000_0000, 32'hF000_0000, 32'h0000_0100, 1'b1);
        set_window(1, 32'h4000_0000, 32'hFF00_0000, 32'h0000_0200, 1'b1);
        do_burst(32'h4000_0040, 4'd9, 8'd0, 0, 0, 0, 0, got);
        check_eq("priority", got, 32'h4000_0140);

        // Address wrap
        set_window(0, 32'h8000_0000, 32'hF000_0000, 32'h9000_0000, 1'b1);
        cfg_write(1, 3, 32'h0);
        do_burst(32'h8000_0000, 4'd1, 8'd0, 0, 0, 0, 0, got);
        check_eq("wrap", got, 32'h1000_0000);

        // Offset rewritten mid-burst: only the next burst sees it
        do_burst(32'h8000_0010, 4'd3, 8'd1, 1, 0, 2, 32'h0000_0100, got);
        check_eq("cfg_mid_old", got, 32'h1000_0010);
        do_burst(32'h8000_0010, 4'd4, 8'd1, 0, 0, 0, 0, got);
        check_eq("cfg_mid_new", got, 32'h8000_0110);

        // Reset during the third of four data beats
        send_aw(32'h8000_0020, 4'd7, 8'd3);
        accept_out_aw(32'h8000_0120, 4'd7, 8'd3, 0, got);
        w_beat(1'b1, 1'b0, 0);
        w_beat(1'b1, 1'b0, 0);
        io_in_wvalid = 1'b1; io_out_wready = 1'b1; io_out_bvalid = 1'b1; io_in_bready = 1'b1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        model_clear();
        @(negedge clock);
        check_eq("midrst_awready", io_in_awready, 1);
        check_eq("midrst_valids", {io_out_awvalid, io_out_wvalid, io_in_bvalid, io_in_wready, io_out_bready}, 64'h0);
        check_eq("midrst_err_count", err_count, 0);
        io_in_wvalid = 1'b0; io_out_wready = 1'b0; io_out_bvalid = 1'b0; io_in_bready = 1'b0;
        @(posedge clock); #1;

        // Windows are cleared by reset, so this must miss
        do_burst(32'h8000_0020, 4'd6, 8'd0, 0, 0, 0, 0, got);

        // Randomized bursts
        for (int r = 0; r < 40; r++) begin
            if (r % 8 == 0) begin
                for (int i = 0; i < NUM_WIN; i++) begin
                    case ($urandom_range(0, 4))
                        0: mk = 32'hFFF0_0000;
                        1: mk = 32'hFF00_0000;
                        2: mk = 32'hF000_0000;
                        3: mk = 32'hFFFF_0000;
                        default: mk = 32'h0;
                    endcase
                    set_window(i, $urandom, mk, $urandom, $urandom_range(0, 3) != 0);
                end
            end
            if ($urandom_range(0, 9) < 6) begin
                w = $urandom_range(0, NUM_WIN - 1);
                a = (m_base[w] & m_mask[w]) | ($urandom & ~m_mask[w]);
            end else begin
                a = $urandom;
            end
            do_burst(a, 4'($urandom), 8'($urandom_range(0, 3)), (r % 5) == 3,
                     $urandom_range(0, NUM_WIN - 1), $urandom_range(0, 3), $urandom, got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_remap_bridge.md
AXI_REMAP_BRIDGE -- requirements
Module: axi_remap_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width on both sides.
REQ-002 SHALL have parameter DATA_W, default 64, write data width; strobe width is DATA_W/8.
REQ-003 SHALL have parameter ID_W, default 4, transaction ID width.
REQ-004 SHALL have parameter NUM_WIN, default 4, number of remap windows (1..16); CW = clog2(NUM_WIN)+2.
REQ-005 SHALL have port clock, input, 1, the single clock.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have io_in_aw{valid,ready,addr,id,len,size,burst}, slave, 1/1/ADDR_W/ID_W/8/3/2, upstream write address.
REQ-008 SHALL have io_in_w{valid,ready,data,strb,last}, slave, 1/1/DATA_W/DATA_W/8/1, upstream write data.
REQ-009 SHALL have io_in_b{valid,ready,resp,id}, slave, 1/1/2/ID_W, upstream write response.
REQ-010 SHALL have io_out_aw*, io_out_w*, io_out_b*, master, same widths, downstream mirror of REQ-007..009.
REQ-011 SHALL have cfg_wen in 1, cfg_addr in CW, cfg_wdata in ADDR_W: register write port.
REQ-012 SHALL have err_count, output, 16, saturating count of locally generated DECERR responses.

Function
REQ-013 Per window i, registers at cfg_addr = 4i+k SHALL be: k=0 base, k=1 mask, k=2 offset, k=3 ctrl (bit0 enable); a cfg_wen write SHALL take effect the next cycle.
REQ-014 Window i SHALL hit when enabled and (awaddr & mask) == (base & mask); lowest hitting index wins.
REQ-015 Translated address SHALL be awaddr + offset, modulo 2^ADDR_W (wrap, no carry out).
REQ-016 FSM states SHALL be IDLE, ADDR, DATA, RESP, ERR_DATA, ERR_RESP; one write burst in flight at a time.
REQ-017 io_in_awready SHALL be 1 only in IDLE; on AW handshake the block captures id/len/size/burst, the translated address and hit result (window snapshot).
REQ-018 IDLE -> ADDR on hit; IDLE -> ERR_DATA on miss.
REQ-019 In ADDR, io_out_awvalid SHALL be 1 from the cycle after acceptance and held with stable payload until io_out_awready; then -> DATA.
REQ-020 In DATA, W SHALL pass combinationally: out_wvalid=in_wvalid, in_wready=out_wready, data/strb/last forwarded; -> RESP on handshake with wlast=1.
REQ-021 W SHALL not be accepted (in_wready=0, out_wvalid=0) in any state other than DATA and ERR_DATA.
REQ-022 In RESP, B SHALL pass combinationally with io_in_bid = captured id; -> IDLE on in B handshake.
REQ-023 In ERR_DATA, io_in_wready SHALL be 1 and beats discarded; -> ERR_RESP on wlast handshake.
REQ-024 In ERR_RESP, io_in_bvalid=1, bresp=2'b11, bid=captured id until bready; -> IDLE; err_count increments, saturating at 0xFFFF.
REQ-025 Downstream io_out_awvalid, io_out_wvalid, io_out_bready SHALL never assert during ERR_DATA/ERR_RESP.
REQ-026 Config writes during a burst SHALL not affect the burst in flight.
REQ-027 Latency: in AW accept to out_awvalid = 1 cycle; W and B add 0 cycles.

Reset
REQ-028 On reset the FSM SHALL enter IDLE; all window registers, err_count and captured fields SHALL clear to 0; all valid outputs 0; io_in_awready 1 from the first cycle after reset.
REQ-029 Reset asserted mid-burst SHALL abandon the burst without completing any handshake.

Verification
REQ-030 Win0 base 0x8000_0000, mask 0xFFF0_0000, offset 0x0010_0000, enabled; AW 0x8000_1000 len 3 id 5 -> out_awaddr 0x8010_1000 one cycle later, 4 beats forwarded, in B id 5 resp OKAY.
REQ-031 No window hit, AW 0x1000_0000 len 1 id 2 -> 2 beats drained, out_awvalid never 1, bresp 2'b11 bid 2, err_count 1.
REQ-032 Win0 and win1 both hit (win1 offset 0x200) -> win0 offset applied.
REQ-033 Offset 0x9000_0000, AW 0x8000_0000 -> out_awaddr 0x1000_0000 (wrap).
REQ-034 Reset during DATA beat 2 of 4 -> next cycle all valids 0, in_awready 1, err_count 0.
REQ-035 cfg write of win0 offset during DATA -> current burst keeps old address; next burst uses new offset.
